// File: rtl/fb_scanout_if.sv
// rtl/fb_scanout_if.sv - framebuffer read and bank-swap bus between scanout and fractal writer
interface fb_scanout_if #(
    parameter int ADDR_W = 19
);
    logic [ADDR_W-1:0] fb_raddr;
    logic              fb_rbank;
    logic [7:0]        fb_rdata;
    logic              swap_req;
    logic              swap_ack;

    modport master (
        output fb_raddr,
        output fb_rbank,
        input  fb_rdata,
        input  swap_req,
        output swap_ack
    );

    modport slave (
        input  fb_raddr,
        input  fb_rbank,
        output fb_rdata,
        output swap_req,
        input  swap_ack
    );
endinterface

// File: rtl/fb_scanout.sv
// rtl/fb_scanout.sv - VGA scanout of a double-banked 8-bit framebuffer through a 3-3-2 palette
module fb_scanout #(
    parameter int         H_VISIBLE   = 640,
    parameter int         H_FRONT     = 16,
    parameter int         H_SYNC      = 96,
    parameter int         H_BACK      = 48,
    parameter int         V_VISIBLE   = 480,
    parameter int         V_FRONT     = 10,
    parameter int         V_SYNC      = 2,
    parameter int         V_BACK      = 33,
    parameter int         ADDR_W      = 19,
    parameter logic [7:0] INSIDE_CODE = 8'hFF
) (
    input  logic         CLOCK_50,
    input  logic         RESET_N,
    fb_scanout_if.master fb,
    output logic         frame_start,
    output logic         VGA_HS,
    output logic         VGA_VS,
    output logic         VGA_BLANK_N,
    output logic         VGA_SYNC_N,
    output logic [7:0]   VGA_R,
    output logic [7:0]   VGA_G,
    output logic [7:0]   VGA_B
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS      = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS      = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_VISIBLE * V_VISIBLE - 1);

    // stage 0: raster position, read address, bank state
    logic              r_run;
    logic [HW-1:0]     r_h_cnt;
    logic [VW-1:0]     r_v_cnt;
    logic [ADDR_W-1:0] r_raddr;
    logic              r_rbank;
    logic              r_swap_ack;
    logic              r_frame_start;
    // stage 1: timing delayed while RAM data returns
    logic              r_vis1;
    logic              r_hs1;
    logic              r_vs1;
    // stage 2: registered pins
    logic              r_vis2;
    logic              r_hs2;
    logic              r_vs2;
    logic [7:0]        r_r;
    logic [7:0]        r_g;
    logic [7:0]        r_b;

    logic [HW-1:0]     w_h_next;
    logic [VW-1:0]     w_v_next;
    logic              w_vis0;
    logic              w_hs0;
    logic              w_vs0;
    logic              w_frame_next;
    logic              w_swap_take;
    logic [7:0]        w_pix_r;
    logic [7:0]        w_pix_g;
    logic [7:0]        w_pix_b;

    // next raster position; held at 0,0 for the first clock after reset so that
    // clock carries the frame_start pulse for the first frame
    always_comb begin
        w_h_next = r_h_cnt;
        w_v_next = r_v_cnt;
        if (r_run) begin
            if (r_h_cnt == H_LAST) begin
                w_h_next = '0;
                w_v_next = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
            end else begin
                w_h_next = r_h_cnt + 1'b1;
            end
        end
    end

    assign w_vis0       = r_run && (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    assign w_hs0        = !((r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END));
    assign w_vs0        = !((r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END));
    assign w_frame_next = (w_h_next == '0) && (w_v_next == '0);
    // swap is only considered at the start of the first blank line, never mid-picture
    assign w_swap_take  = r_run && (r_h_cnt == '0) && (r_v_cnt == V_VIS) && fb.swap_req;

    // stage 0 registers: counters, incremental address, bank swap handshake
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_run         <= 1'b0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_raddr       <= '0;
            r_rbank       <= 1'b0;
            r_swap_ack    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_run         <= 1'b1;
            r_h_cnt       <= w_h_next;
            r_v_cnt       <= w_v_next;
            r_frame_start <= w_frame_next;
            r_swap_ack    <= w_swap_take;
            r_rbank       <= r_rbank ^ w_swap_take;
            if (w_frame_next) begin
                r_raddr <= '0;
            end else if (w_vis0 && (r_raddr != LAST_ADDR)) begin
                r_raddr <= r_raddr + 1'b1;
            end
        end
    end

    // stage 1: delay timing one clock to line up with RAM read data
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_vis1 <= 1'b0;
            r_hs1  <= 1'b1;
            r_vs1  <= 1'b1;
        end else begin
            r_vis1 <= w_vis0;
            r_hs1  <= w_hs0;
            r_vs1  <= w_vs0;
        end
    end

    // 3-3-2 palette with bit replication so full-scale codes reach 8'hFF
    always_comb begin
        w_pix_r = '0;
        w_pix_g = '0;
        w_pix_b = '0;
        if (r_vis1 && (fb.fb_rdata != INSIDE_CODE)) begin
            w_pix_r = {fb.fb_rdata[7:5], fb.fb_rdata[7:5], fb.fb_rdata[7:6]};
            w_pix_g = {fb.fb_rdata[4:2], fb.fb_rdata[4:2], fb.fb_rdata[4:3]};
            w_pix_b = {4{fb.fb_rdata[1:0]}};
        end
    end

    // stage 2: registered pins, colour and sync aligned
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_vis2 <= 1'b0;
            r_hs2  <= 1'b1;
            r_vs2  <= 1'b1;
            r_r    <= '0;
            r_g    <= '0;
            r_b    <= '0;
        end else begin
            r_vis2 <= r_vis1;
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
            r_r    <= w_pix_r;
            r_g    <= w_pix_g;
            r_b    <= w_pix_b;
        end
    end

    assign fb.fb_raddr = r_raddr;
    assign fb.fb_rbank = r_rbank;
    assign fb.swap_ack = r_swap_ack;
    assign frame_start = r_frame_start;
    assign VGA_HS      = r_hs2;
    assign VGA_VS      = r_vs2;
    assign VGA_BLANK_N = r_vis2;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = r_r;
    assign VGA_G       = r_g;
    assign VGA_B       = r_b;
endmodule

// File: tb/tb_fb_scanout.sv
// tb/tb_fb_scanout.sv - scoreboard bench for fb_scanout at reduced 64x48 raster
module tb_fb_scanout;
    localparam int HV = 64, HF = 4, HS = 8, HB = 4;
    localparam int VV = 48, VF = 2, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int NPIX = HV * VV;
    localparam int SWAP_POS = VV * HT;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
    logic [7:0] vga_r, vga_g, vga_b;

    fb_scanout_if #(.ADDR_W(19)) fb_if ();

    fb_scanout #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .ADDR_W(19), .INSIDE_CODE(8'hFF)
    ) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .fb(fb_if),
        .frame_start(frame_start), .VGA_HS(vga_hs), .VGA_VS(vga_vs),
        .VGA_BLANK_N(vga_blank_n), .VGA_SYNC_N(vga_sync_n),
        .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b)
    );

    always #5 clk = ~clk;

    // two-bank sync-read RAM
    logic [7:0] mem [0:1][0:NPIX-1];
    int         ram_a;
    always @(posedge clk) begin
        ram_a = int'(fb_if.fb_raddr);
        fb_if.fb_rdata <= (ram_a < NPIX) ? mem[fb_if.fb_rbank][ram_a] : 8'h00;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pal(input logic [7:0] d);
        logic [7:0] r, g, b;
        if (d == 8'hFF) return 24'h0;
        r = {d[7:5], d[7:5], d[7:6]};
        g = {d[4:2], d[4:2], d[4:3]};
        b = 8'(d[1:0] * 8'h55);
        return {r, g, b};
    endfunction

    // reference: pins at cycle tt show raster position tt-3, stage 0 is at tt-1
    function automatic logic [48:0] expect_at(input int tt, input bit bank, input bit ack);
        logic fs, hs, vs, bl;
        logic [23:0] rgb;
        int p, q, x, y, cnt;
        p = (tt - 1) % FT;
        fs = (p == 0);
        y = p / HT;
        x = p % HT;
        cnt = (y < VV) ? y * HV + ((x < HV) ? x : HV) : NPIX;
        if (cnt > NPIX - 1) cnt = NPIX - 1;
        hs = 1'b1; vs = 1'b1; bl = 1'b0; rgb = 24'h0;
        if (tt >= 3) begin
            q = (tt - 3) % FT;
            y = q / HT;
            x = q % HT;
            hs = !(x >= HV + HF && x < HV + HF + HS);
            vs = !(y >= VV + VF && y < VV + VF + VS);
            bl = (x < HV) && (y < VV);
            if (bl) rgb = pal(mem[bank][y * HV + x]);
        end
        return {fs, ack, bank, hs, vs, bl, rgb, 19'(cnt)};
    endfunction

    int          t = 0;
    bit          m_bank = 1'b0;
    bit          m_ack;
    logic [48:0] exp_q[$];

    // model: advances one raster position per clock and queues the expected pins
    always @(posedge clk) begin
        if (!rst_n) begin
            t = 0;
            m_bank = 1'b0;
            exp_q.delete();
        end else begin
            m_ack = (t >= 1) && (((t - 1) % FT) == SWAP_POS) && (fb_if.swap_req == 1'b1);
            if (m_ack) m_bank = ~m_bank;
            t = t + 1;
            exp_q.push_back(expect_at(t, m_bank, m_ack));
        end
    end

    int          ack_cnt = 0;
    int          last_fs = -1;
    int          max_ra = 0;
    logic [48:0] mon_e, mon_a;

    // monitor: compares DUT pins against the queued expectation each cycle
    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {frame_start, fb_if.swap_ack, fb_if.fb_rbank, vga_hs, vga_vs, vga_blank_n,
                     vga_r, vga_g, vga_b, fb_if.fb_raddr};
            chk($sformatf("pins_t%0d", t), 64'(mon_a), 64'(mon_e));
            if (fb_if.swap_ack) ack_cnt++;
            if (frame_start) begin
                if (last_fs >= 0) chk("frame_period", 64'(t - last_fs), 64'(FT));
                last_fs = t;
            end
            if (int'(fb_if.fb_raddr) > max_ra) max_ra = int'(fb_if.fb_raddr);
        end
    end

    task automatic wait_stage0(input int target);
        int n;
        n = 0;
        while ((t - 1) != target && n < 30000) begin
            @(negedge clk);
            n++;
        end
        if ((t - 1) != target) chk("wait_timeout", 64'(t - 1), 64'(target));
    endtask

    logic [7:0] special [0:4];
    int         sx, sy;

    initial begin
        rst_n = 1'b0;
        fb_if.swap_req = 1'b0;
        special[0] = 8'hFF; special[1] = 8'hE0; special[2] = 8'h1C;
        special[3] = 8'h03; special[4] = 8'h00;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NPIX; i++) mem[b][i] = 8'($urandom);
            for (int i = b; i < NPIX; i += 37) mem[b][i] = 8'hFF;
            for (int i = 0; i < 5; i++) mem[b][i + b * 100] = special[i];
        end

        repeat (4) @(negedge clk);
        chk("rst_frame_start", 64'(frame_start), 64'd0);
        chk("rst_hs", 64'(vga_hs), 64'd1);
        chk("rst_vs", 64'(vga_vs), 64'd1);
        chk("rst_blank_n", 64'(vga_blank_n), 64'd0);
        chk("rst_rgb", 64'({vga_r, vga_g, vga_b}), 64'd0);
        chk("rst_raddr", 64'(fb_if.fb_raddr), 64'd0);
        chk("rst_bank", 64'(fb_if.fb_rbank), 64'd0);
        chk("rst_ack", 64'(fb_if.swap_ack), 64'd0);
        chk("sync_n", 64'(vga_sync_n), 64'd0);
        rst_n = 1'b1;

        // request raised mid-picture and held across two frame boundaries
        sy = $urandom_range(5, 40);
        sx = $urandom_range(0, HV - 1);
        wait_stage0(sy * HT + sx);
        fb_if.swap_req = 1'b1;
        wait_stage0(FT + SWAP_POS + 1);
        fb_if.swap_req = 1'b0;

        // request rising on the sampling clock itself
        wait_stage0(2 * FT + SWAP_POS);
        fb_if.swap_req = 1'b1;
        wait_stage0(2 * FT + SWAP_POS + 1);
        fb_if.swap_req = 1'b0;

        // pending request, then asynchronous reset at h=30 v=10
        wait_stage0(3 * FT + 5 * HT + 10);
        chk("acks_before_reset", 64'(ack_cnt), 64'd3);
        fb_if.swap_req = 1'b1;
        wait_stage0(3 * FT + 10 * HT + 30);
        chk("bank_before_reset", 64'(fb_if.fb_rbank), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_blank_n", 64'(vga_blank_n), 64'd0);
        chk("mid_rst_bank", 64'(fb_if.fb_rbank), 64'd0);
        chk("mid_rst_raddr", 64'(fb_if.fb_raddr), 64'd0);
        chk("mid_rst_hs_vs", 64'({vga_hs, vga_vs}), 64'd3);
        chk("mid_rst_rgb", 64'({vga_r, vga_g, vga_b}), 64'd0);
        chk("mid_rst_fs_ack", 64'({frame_start, fb_if.swap_ack}), 64'd0);
        fb_if.swap_req = 1'b0;
        last_fs = -1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        repeat (FT + 200) @(negedge clk);
        chk("acks_total", 64'(ack_cnt), 64'd3);
        chk("raddr_peak", 64'(max_ra), 64'(NPIX - 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
